// File: rtl/loader_arb_pkg.sv
// rtl/loader_arb_pkg.sv - shared types and constants for the loader memory arbiter
// Contents: arbiter state and grant encodings, timeout read-data value,
// saturating 32-bit increment used by the optional ARB_PERF_CNT_EN counters.
package loader_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_LD,
        G_CPU,
        G_PPU
    } grant_t;

    // Read data returned to a requester whose transaction was aborted.
    localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/loader_wr_fifo.sv
// rtl/loader_wr_fifo.sv - posted-write FIFO for the game loader stream
// Ports: clk, reset (async, active-high); i_push/i_push_data write side;
// i_pop/o_pop_data read side (o_pop_data is the head entry, valid when not empty);
// o_full, o_empty, o_count status.
module loader_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (o_count == CW'(DEPTH));
    assign o_empty    = (o_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            o_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                o_count <= o_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                o_count <= o_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/loader_mem_arbiter.sv
// rtl/loader_mem_arbiter.sv - shares one cartridge memory port between loader, CPU and PPU
// Ports: clk, reset (async, active-high); ld_* loader write stream and FIFO status;
// cpu_* read/write request/ack; ppu_* read request/ack; mem_* SDRAM controller side;
// timeout sticky abort flag. Optional macro ARB_PERF_CNT_EN adds cnt_ld, cnt_cpu,
// cnt_ppu (grants) and cnt_stall (cycles a requester waits while another is served).
module loader_mem_arbiter
    import loader_arb_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_busy,
    input  logic              ld_write,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_full,
    output logic              ld_drained,
    output logic              ld_overflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       cnt_ld,
    output logic [31:0]       cnt_cpu,
    output logic [31:0]       cnt_ppu,
    output logic [31:0]       cnt_stall,
`endif
    output logic              timeout
);

    localparam int FW = ADDR_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    arb_state_t        r_state;
    grant_t            r_grant;
    grant_t            w_grant;
    logic [TW-1:0]     r_wait;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;
    logic [FW-1:0]     w_fifo_q;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_rdata;

    assign {w_ld_addr, w_ld_data} = w_fifo_q;

    loader_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (ld_write),
        .i_push_data ({ld_addr, ld_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_q),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // While loading only the FIFO may win; at runtime PPU > CPU > leftover writes.
    always_comb begin
        w_grant = G_NONE;
        if (ld_busy) begin
            if (!w_empty) w_grant = G_LD;
        end else if (ppu_req) begin
            w_grant = G_PPU;
        end else if (cpu_req) begin
            w_grant = G_CPU;
        end else if (!w_empty) begin
            w_grant = G_LD;
        end
    end

    assign w_pop      = (r_state == S_IDLE) && (w_grant == G_LD);
    assign ld_full    = (w_count == FULL_CNT);
    // Held low during reset so every output reads 0 while reset is asserted.
    assign ld_drained = w_empty && (r_state == S_IDLE) && !reset;
    assign w_rdata    = mem_ack ? mem_rdata : DATA_W'(RDATA_TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= G_NONE;
            r_wait      <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_ack     <= 1'b0;
            ppu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            ppu_rdata   <= '0;
            timeout     <= 1'b0;
            ld_overflow <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ppu_ack <= 1'b0;
            if (ld_write && w_full && !w_pop) begin
                ld_overflow <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_grant <= w_grant;
                    r_wait  <= '0;
                    if (w_grant != G_NONE) begin
                        mem_req <= 1'b1;
                        r_state <= S_ISSUE;
                        case (w_grant)
                            G_PPU: begin
                                mem_we    <= 1'b0;
                                mem_addr  <= ppu_addr;
                                mem_wdata <= '0;
                            end
                            G_CPU: begin
                                mem_we    <= cpu_we;
                                mem_addr  <= cpu_addr;
                                mem_wdata <= cpu_wdata;
                            end
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= w_ld_addr;
                                mem_wdata <= w_ld_data;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    // mem_ack wins if it arrives on the last allowed wait cycle.
                    if (mem_ack || (r_wait == TMO_LAST)) begin
                        mem_req <= 1'b0;
                        r_state <= S_DONE;
                        if (!mem_ack) timeout <= 1'b1;
                        // Ack is registered here so it is high for the whole S_DONE cycle.
                        if (r_grant == G_CPU) begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= w_rdata;
                        end
                        if (r_grant == G_PPU) begin
                            ppu_ack   <= 1'b1;
                            ppu_rdata <= w_rdata;
                        end
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    grant_t w_served;
    logic   w_stall;

    always_comb begin
        w_served = (r_state == S_IDLE) ? w_grant : r_grant;
        w_stall  = 1'b0;
        if (r_state != S_DONE) begin
            w_stall = (ppu_req && (w_served != G_PPU)) ||
                      (cpu_req && (w_served != G_CPU)) ||
                      (!w_empty && (w_served != G_LD));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_ld    <= '0;
            cnt_cpu   <= '0;
            cnt_ppu   <= '0;
            cnt_stall <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_grant == G_LD)  cnt_ld  <= sat_inc32(cnt_ld);
                if (w_grant == G_CPU) cnt_cpu <= sat_inc32(cnt_cpu);
                if (w_grant == G_PPU) cnt_ppu <= sat_inc32(cnt_ppu);
            end
            if (w_stall) cnt_stall <= sat_inc32(cnt_stall);
        end
    end
`endif

endmodule

// File: tb/tb_loader_mem_arbiter.sv
// tb/tb_loader_mem_arbiter.sv - directed self-checking bench for loader_mem_arbiter
module tb_loader_mem_arbiter;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              ld_busy;
    logic              ld_write;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_full;
    logic              ld_drained;
    logic              ld_overflow;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic              ppu_ack;
    logic [DATA_W-1:0] ppu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              timeout;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       cnt_ld;
    logic [31:0]       cnt_cpu;
    logic [31:0]       cnt_ppu;
    logic [31:0]       cnt_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ack_en  = 0;
    int ack_dly = 0;

    logic [ADDR_W-1:0] tx_addr [$];
    logic [DATA_W-1:0] tx_data [$];
    logic              tx_we   [$];

    loader_mem_arbiter u_dut (
        .clk         (clk),
        .reset       (reset),
        .ld_busy     (ld_busy),
        .ld_write    (ld_write),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_full     (ld_full),
        .ld_drained  (ld_drained),
        .ld_overflow (ld_overflow),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .ppu_req     (ppu_req),
        .ppu_addr    (ppu_addr),
        .ppu_ack     (ppu_ack),
        .ppu_rdata   (ppu_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
`ifdef ARB_PERF_CNT_EN
        .cnt_ld      (cnt_ld),
        .cnt_cpu     (cnt_cpu),
        .cnt_ppu     (cnt_ppu),
        .cnt_stall   (cnt_stall),
`endif
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks ack_dly cycles after mem_req rises; read data = addr[7:0]^0x5A.
    initial begin
        int w;
        w         = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && (ack_en != 0)) begin
                if (w >= ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr[7:0] ^ 8'h5A;
                    tx_addr.push_back(mem_addr);
                    tx_data.push_back(mem_wdata);
                    tx_we.push_back(mem_we);
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_write = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_write = 1'b0;
    endtask

    task automatic clear_log();
        tx_addr.delete();
        tx_data.delete();
        tx_we.delete();
    endtask

    task automatic wait_tx(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_addr.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic              ok;
        int                seen_ack;
        int                seen_req;
        int                p_first;
        int                c_first;
        int                p_hi;
        int                c_hi;
        int                hi;
        logic              done;
        logic [ADDR_W-1:0] e_a [3];
        logic [DATA_W-1:0] e_d [3];

        reset     = 1'b1;
        ld_busy   = 1'b0;
        ld_write  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ppu_req   = 1'b0;
        ppu_addr  = '0;

        // Reset state
        tick(2);
        check_val("rst_mem_req", 64'(mem_req), 64'd0);
        check_val("rst_cpu_ack", 64'(cpu_ack), 64'd0);
        check_val("rst_ppu_ack", 64'(ppu_ack), 64'd0);
        check_val("rst_drained", 64'(ld_drained), 64'd0);
        check_val("rst_full", 64'(ld_full), 64'd0);
        check_val("rst_overflow", 64'(ld_overflow), 64'd0);
        check_val("rst_timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        tick(1);
        check_val("rst_rel_drained", 64'(ld_drained), 64'd1);
        check_val("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check_val("rst_ppu_rdata", 64'(ppu_rdata), 64'd0);

        // 1: loader writes drained in order while busy
        clear_log();
        ack_en  = 1;
        ack_dly = 2;
        ld_busy = 1'b1;
        push(22'h000010, 8'hA5);
        push(22'h000011, 8'h5A);
        push(22'h000012, 8'h3C);
        check_val("t1_pending_drained", 64'(ld_drained), 64'd0);
        wait_tx(3, 100, ok);
        check_val("t1_writes_done", 64'(ok), 64'd1);
        e_a = '{22'h000010, 22'h000011, 22'h000012};
        e_d = '{8'hA5, 8'h5A, 8'h3C};
        if (tx_addr.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("t1_addr%0d", i), 64'(tx_addr[i]), 64'(e_a[i]));
                check_val($sformatf("t1_data%0d", i), 64'(tx_data[i]), 64'(e_d[i]));
                check_val($sformatf("t1_we%0d", i), 64'(tx_we[i]), 64'd1);
            end
        end
        tick(3);
        check_val("t1_drained", 64'(ld_drained), 64'd1);

        // 2: CPU locked out while loader busy, served after ld_busy falls
        clear_log();
        cpu_we   = 1'b0;
        cpu_addr = 22'h100000;
        cpu_req  = 1'b1;
        seen_ack = 0;
        seen_req = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack) seen_ack++;
            if (mem_req) seen_req++;
        end
        check_val("t2_lock_ack", 64'(seen_ack), 64'd0);
        check_val("t2_lock_req", 64'(seen_req), 64'd0);
        ld_busy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                ok      = 1'b1;
                cpu_req = 1'b0;
                break;
            end
        end
        check_val("t2_ack_seen", 64'(ok), 64'd1);
        check_val("t2_rdata", 64'(cpu_rdata), 64'h5A);
        if (tx_addr.size() >= 1) begin
            check_val("t2_addr", 64'(tx_addr[0]), 64'h100000);
            check_val("t2_we", 64'(tx_we[0]), 64'd0);
        end
        tick(1);
        check_val("t2_ack_width", 64'(cpu_ack), 64'd0);
        cpu_req = 1'b0;

        // 3: simultaneous PPU and CPU reads, PPU first, minimum latency
        clear_log();
        ack_dly  = 0;
        ppu_addr = 22'h200001;
        cpu_addr = 22'h000042;
        ppu_req  = 1'b1;
        cpu_req  = 1'b1;
        p_first  = -1;
        c_first  = -1;
        p_hi     = 0;
        c_hi     = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (ppu_ack) begin
                p_hi++;
                if (p_first < 0) p_first = cyc;
                ppu_req = 1'b0;
            end
            if (cpu_ack) begin
                c_hi++;
                if (c_first < 0) c_first = cyc;
                cpu_req = 1'b0;
            end
        end
        check_val("t3_ppu_lat", 64'(p_first), 64'd2);
        check_val("t3_cpu_lat", 64'(c_first), 64'd5);
        check_val("t3_ppu_width", 64'(p_hi), 64'd1);
        check_val("t3_cpu_width", 64'(c_hi), 64'd1);
        check_val("t3_ppu_rdata", 64'(ppu_rdata), 64'h5B);
        check_val("t3_cpu_rdata", 64'(cpu_rdata), 64'h18);
        if (tx_addr.size() >= 2) begin
            check_val("t3_first_addr", 64'(tx_addr[0]), 64'h200001);
            check_val("t3_second_addr", 64'(tx_addr[1]), 64'h000042);
        end
        ppu_req = 1'b0;
        cpu_req = 1'b0;

        // 4+5: CPU read never acked; FIFO fills behind it; then timeout
        clear_log();
        ack_en   = 0;
        cpu_we   = 1'b0;
        cpu_addr = 22'h0000AB;
        cpu_req  = 1'b1;
        hi       = 0;
        done     = 1'b0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (j == 4) check_val("t4_full_after3", 64'(ld_full), 64'd0);
            if (j == 5) begin
                check_val("t4_full_after4", 64'(ld_full), 64'd1);
                check_val("t4_ovf_after4", 64'(ld_overflow), 64'd0);
            end
            if (j == 6) begin
                check_val("t4_ovf_after5", 64'(ld_overflow), 64'd1);
                check_val("t4_full_after5", 64'(ld_full), 64'd1);
            end
            if (j >= 1 && j <= 5) begin
                ld_write = 1'b1;
                ld_addr  = 22'h000020 + ADDR_W'(j);
                ld_data  = 8'h10 + DATA_W'(j);
            end else begin
                ld_write = 1'b0;
            end
            if (mem_req) begin
                hi++;
            end else if (j > 0) begin
                done = 1'b1;
                break;
            end
        end
        ld_write = 1'b0;
        check_val("t5_req_dropped", 64'(done), 64'd1);
        check_val("t5_req_cycles", 64'(hi), 64'd255);
        check_val("t5_cpu_ack", 64'(cpu_ack), 64'd1);
        check_val("t5_cpu_rdata", 64'(cpu_rdata), 64'hFF);
        check_val("t5_timeout", 64'(timeout), 64'd1);
        cpu_req = 1'b0;
        ack_en  = 1;
        ack_dly = 0;
        wait_tx(4, 100, ok);
        check_val("t4_drain_done", 64'(ok), 64'd1);
        tick(10);
        check_val("t4_entries", 64'(tx_addr.size()), 64'd4);
        if (tx_addr.size() >= 4) begin
            check_val("t4_first_addr", 64'(tx_addr[0]), 64'h000021);
            check_val("t4_last_addr", 64'(tx_addr[3]), 64'h000024);
            check_val("t4_last_data", 64'(tx_data[3]), 64'h14);
        end
        check_val("t4_drained", 64'(ld_drained), 64'd1);
        check_val("t4_ovf_sticky", 64'(ld_overflow), 64'd1);
        check_val("t5_timeout_sticky", 64'(timeout), 64'd1);

        // 6: reset in S_ISSUE with two entries queued
        clear_log();
        ack_en  = 0;
        ld_busy = 1'b1;
        push(22'h000030, 8'h01);
        push(22'h000031, 8'h02);
        push(22'h000032, 8'h03);
        check_val("t6_pre_req", 64'(mem_req), 64'd1);
        check_val("t6_pre_drained", 64'(ld_drained), 64'd0);
        reset = 1'b1;
        #1;
        check_val("t6_async_drop", 64'(mem_req), 64'd0);
        tick(2);
        reset  = 1'b0;
        ack_en = 1;
        tick(1);
        check_val("t6_drained", 64'(ld_drained), 64'd1);
        check_val("t6_full", 64'(ld_full), 64'd0);
        check_val("t6_timeout_clr", 64'(timeout), 64'd0);
        seen_ack = 0;
        seen_req = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack || ppu_ack) seen_ack++;
            if (mem_req) seen_req++;
        end
        check_val("t6_stray_ack", 64'(seen_ack), 64'd0);
        check_val("t6_stray_req", 64'(seen_req), 64'd0);
        check_val("t6_no_tx", 64'(tx_addr.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
